// File: rtl/bcd_display_mux.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot and digit blink.
// Optional leading-zero blanking is enabled by defining BCD_DISPLAY_LZB_EN.
module bcd_display_mux #(
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 12500000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Qdata,
   input  logic [3:0]  blink,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_start
);

   localparam int SC_W = $clog2(SCAN_DIV);
   localparam int BL_W = $clog2(BLINK_DIV);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
   localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
   localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
   localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

   logic [SC_W-1:0] sc_r;
   logic [1:0]      idx_r;
   logic [15:0]     shadow_data_r;
   logic [3:0]      shadow_blink_r;
   logic [BL_W-1:0] bl_cnt_r;
   logic            ph_r;
   logic            init_r;
   logic [3:0]      an_r;
   logic [6:0]      seg_r;
   logic            frame_start_r;

   logic            scan_wrap_s;
   logic            snapshot_s;
   logic [3:0]      digit_s;
   logic [3:0]      an_hot_s;
   logic            lzb_blank_s;
   logic [6:0]      pattern_s;

   function automatic logic [6:0] decode_bcd(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   // Digit selection, snapshot strobe and active-high segment pattern
   always_comb begin
      scan_wrap_s = (sc_r == SC_LAST);
      snapshot_s  = init_r || (scan_wrap_s && (idx_r == 2'd3));
      case (idx_r)
         2'd0:    begin digit_s = shadow_data_r[3:0];   an_hot_s = 4'b0001; end
         2'd1:    begin digit_s = shadow_data_r[7:4];   an_hot_s = 4'b0010; end
         2'd2:    begin digit_s = shadow_data_r[11:8];  an_hot_s = 4'b0100; end
         2'd3:    begin digit_s = shadow_data_r[15:12]; an_hot_s = 4'b1000; end
         default: begin digit_s = shadow_data_r[3:0];   an_hot_s = 4'b0001; end
      endcase
`ifdef BCD_DISPLAY_LZB_EN
      case (idx_r)
         2'd1:    lzb_blank_s = (shadow_data_r[15:4] == 12'h000);
         2'd2:    lzb_blank_s = (shadow_data_r[15:8] == 8'h00);
         2'd3:    lzb_blank_s = (shadow_data_r[15:12] == 4'h0);
         default: lzb_blank_s = 1'b0;
      endcase
`else
      lzb_blank_s = 1'b0;
`endif
      if (lzb_blank_s || (shadow_blink_r[idx_r] && !ph_r)) begin
         pattern_s = 7'h00;
      end else begin
         pattern_s = decode_bcd(digit_s);
      end
   end

   // Scan position and once-per-frame snapshot of the display data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sc_r           <= '0;
         idx_r          <= 2'd0;
         shadow_data_r  <= 16'h0000;
         shadow_blink_r <= 4'h0;
         init_r         <= 1'b1;
      end else begin
         init_r <= 1'b0;
         if (scan_wrap_s) begin
            sc_r  <= '0;
            idx_r <= idx_r + 2'd1;
         end else begin
            sc_r  <= sc_r + SC_ONE;
         end
         if (snapshot_s) begin
            shadow_data_r  <= Qdata;
            shadow_blink_r <= blink;
         end else begin
            shadow_data_r  <= shadow_data_r;
            shadow_blink_r <= shadow_blink_r;
         end
      end
   end

   // Free-running blink phase, independent of the scan
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bl_cnt_r <= '0;
         ph_r     <= 1'b1;
      end else if (bl_cnt_r == BL_LAST) begin
         bl_cnt_r <= '0;
         ph_r     <= ~ph_r;
      end else begin
         bl_cnt_r <= bl_cnt_r + BL_ONE;
      end
   end

   // Registered display outputs; frame_start marks the first cycle of digit 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_r          <= AN_POL;
         seg_r         <= SEG_POL;
         frame_start_r <= 1'b0;
      end else begin
         an_r          <= an_hot_s ^ AN_POL;
         seg_r         <= pattern_s ^ SEG_POL;
         frame_start_r <= (idx_r == 2'd0) && (sc_r == '0);
      end
   end

   assign an          = an_r;
   assign seg         = seg_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized self-checking bench for bcd_display_mux against a cycle-count reference model.
module tb_bcd_display_mux;

   localparam int SD = 4;
   localparam int BD = 16;
   localparam int FRAME = 4 * SD;
   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] Qdata = 16'h0000;
   logic [3:0]  blink = 4'h0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_start;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: edges since reset release and the latched frame data
   int          n;
   logic [15:0] sh_q;
   logic [3:0]  sh_b;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fs;

   bcd_display_mux #(.SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .Qdata(Qdata), .blink(blink),
      .an(an), .seg(seg), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] model_pat(input int k);
      int d;
      int v;
      bit ph;
      logic [6:0] p;
      d  = (k / SD) % 4;
      ph = ((k / BD) % 2) == 0;
      v  = (sh_q >> (4 * d)) & 16'h000F;
      p  = (v < 10) ? SEG_TAB[v] : 7'h00;
`ifdef BCD_DISPLAY_LZB_EN
      if (d > 0 && (sh_q >> (4 * d)) == 16'h0000) p = 7'h00;
`endif
      if (sh_b[d] && !ph) p = 7'h00;
      return p;
   endfunction

   // Model: output after edge k reflects the scan position / data after k-1 edges
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n <= 0; sh_q <= 16'h0000; sh_b <= 4'h0;
         exp_an <= 4'hF; exp_seg <= 7'h7F; exp_fs <= 1'b0;
      end else begin
         exp_an  <= ~(4'b0001 << ((n / SD) % 4));
         exp_seg <= ~model_pat(n);
         exp_fs  <= (n % FRAME) == 0;
         if (n == 0 || (n % FRAME) == FRAME - 1) begin
            sh_q <= Qdata;
            sh_b <= blink;
         end
         n <= n + 1;
      end
   end

   task test_reset;
      bit found;
      rst = 1'b0; Qdata = 16'h9675; blink = 4'h0;
      repeat (3) @(negedge clk);
      n_assert++;
      if ({an, seg, frame_start} !== {4'b1111, 7'h7F, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_hold: an=%b seg=%h fs=%b expected an=1111 seg=7f fs=0", an, seg, frame_start);
      end
      rst = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 2 && !found; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            found = 1'b1;
            n_assert++;
            if (an !== 4'b1110) begin
               n_fail++;
               $display("FAIL reset_first_an: an=%b expected 1110", an);
            end
         end
      end
      n_assert++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_first_frame: no frame_start within 2 clocks after release");
      end
   endtask

   task test_scan;
      int fs_cnt;
      fs_cnt = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) fs_cnt++;
         n_assert++;
         if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            n_fail++;
            $display("FAIL scan: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                     an, seg, frame_start, exp_an, exp_seg, exp_fs);
         end
      end
      n_assert++;
      if (fs_cnt != 3) begin
         n_fail++;
         $display("FAIL scan_frame_count: got %0d pulses expected 3", fs_cnt);
      end
   endtask

   task test_snapshot;
      bit found;
      bit frame_done;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (an === 4'b1101) found = 1'b1;
      end
      n_assert++;
      if (!found) begin
         n_fail++;
         $display("FAIL snapshot_wait: an never reached 1101 (an=%b)", an);
      end
      Qdata = 16'h1234;
      frame_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) frame_done = 1'b1;
         if (!frame_done && an === 4'b1011) begin
            n_assert++;
            if (seg !== 7'h02) begin
               n_fail++;
               $display("FAIL snapshot_old_d2: seg=%h expected 02", seg);
            end
         end
         if (!frame_done && an === 4'b0111) begin
            n_assert++;
            if (seg !== 7'h10) begin
               n_fail++;
               $display("FAIL snapshot_old_d3: seg=%h expected 10", seg);
            end
         end
         n_assert++;
         if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            n_fail++;
            $display("FAIL snapshot: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                     an, seg, frame_start, exp_an, exp_seg, exp_fs);
         end
      end
   endtask

   task test_blink;
      Qdata = 16'h0005; blink = 4'b0001;
      for (int i = 0; i < 96; i++) begin
         @(negedge clk);
         n_assert++;
         if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            n_fail++;
            $display("FAIL blink: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                     an, seg, frame_start, exp_an, exp_seg, exp_fs);
         end
      end
      blink = 4'h0;
   endtask

   task test_invalid;
      Qdata = 16'h000A;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         n_assert++;
         if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            n_fail++;
            $display("FAIL invalid: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                     an, seg, frame_start, exp_an, exp_seg, exp_fs);
         end
      end
   endtask

   task test_reset_midscan;
      Qdata = 16'h4321;
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_assert++;
      if ({an, seg, frame_start} !== {4'b1111, 7'h7F, 1'b0}) begin
         n_fail++;
         $display("FAIL midscan_reset: an=%b seg=%h fs=%b expected an=1111 seg=7f fs=0", an, seg, frame_start);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_assert++;
      if (an !== 4'b1110) begin
         n_fail++;
         $display("FAIL midscan_restart: an=%b expected 1110", an);
      end
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         n_assert++;
         if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            n_fail++;
            $display("FAIL midscan_after: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                     an, seg, frame_start, exp_an, exp_seg, exp_fs);
         end
      end
   endtask

   task test_random;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n_assert++;
         if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            n_fail++;
            $display("FAIL random: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                     an, seg, frame_start, exp_an, exp_seg, exp_fs);
         end
         if ($urandom_range(0, 7) == 0) begin
            Qdata = 16'($urandom);
            blink = 4'($urandom_range(0, 15));
         end
      end
      blink = 4'h0;
   endtask

`ifdef BCD_DISPLAY_LZB_EN
   task test_lzb;
      logic [15:0] pat_q [3];
      logic [6:0]  pat_e [3][4];
      logic [6:0]  e;
      pat_q[0] = 16'h0005; pat_e[0] = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
      pat_q[1] = 16'h0000; pat_e[1] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
      pat_q[2] = 16'h0105; pat_e[2] = '{7'h12, 7'h40, 7'h79, 7'h7F};
      blink = 4'h0;
      for (int p = 0; p < 3; p++) begin
         Qdata = pat_q[p];
         repeat (20) @(negedge clk);
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (an)
               4'b1110: e = pat_e[p][0];
               4'b1101: e = pat_e[p][1];
               4'b1011: e = pat_e[p][2];
               4'b0111: e = pat_e[p][3];
               default: e = 7'hxx;
            endcase
            n_assert++;
            if (seg !== e) begin
               n_fail++;
               $display("FAIL lzb: data=%h an=%b seg=%h expected %h", pat_q[p], an, seg, e);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_snapshot();
      test_blink();
      test_invalid();
      test_reset_midscan();
      test_random();
`ifdef BCD_DISPLAY_LZB_EN
      test_lzb();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
